// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the serial BCD subtractor.
package bcd_pkg;

  localparam int unsigned DIGIT_W   = 4;
  localparam logic [3:0]  BCD_MAX   = 4'd9;
  localparam logic [4:0]  BCD_RADIX = 5'd10;

  typedef enum logic [1:0] {IDLE, SUB, NEG, DONE} state_e;

endpackage

// File: rtl/bcd_sub_digit.sv
// Single-digit BCD borrow subtractor: d = x - y - brw_in, wrapped into 0..9.
module bcd_sub_digit
  import bcd_pkg::*;
(
  input  logic [3:0] i_x,
  input  logic [3:0] i_y,
  input  logic       i_brw_in,
  output logic [3:0] o_d,
  output logic       o_brw_out
);

  logic [4:0] w_t;
  logic [4:0] w_adj;

  // 5-bit two's-complement difference; bit 4 set means the digit went negative.
  always_comb begin
    w_t       = {1'b0, i_x} - {1'b0, i_y} - {4'b0000, i_brw_in};
    w_adj     = w_t + BCD_RADIX;
    o_brw_out = w_t[4];
    o_d       = o_brw_out ? w_adj[3:0] : w_t[3:0];
  end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Multi-digit BCD subtractor, one digit per clock LSD first, with optional
// ten's-complement to sign/magnitude second pass.
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int unsigned N_DIGITS   = 4,
  parameter bit          SIGNED_MAG = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [4*N_DIGITS-1:0] i_a,
  input  logic [4*N_DIGITS-1:0] i_b,
  input  logic                  i_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*N_DIGITS-1:0] o_diff,
  output logic                  o_bout,
  output logic                  o_neg,
  output logic                  o_err
);

  localparam int unsigned W  = DIGIT_W * N_DIGITS;
  localparam int unsigned CW = $clog2(N_DIGITS + 1);

  state_e          r_state, w_state_next;
  logic [W-1:0]    r_a, r_b, r_diff;
  logic [CW-1:0]   r_cnt;
  logic            r_brw, r_bout, r_neg, r_err;

  logic            w_capture, w_last, w_in_err;
  logic [3:0]      w_x, w_y, w_d;
  logic            w_brw_out;
  logic [W-1:0]    w_diff_shift;

  assign o_busy    = (r_state == SUB) || (r_state == NEG);
  assign o_done    = (r_state == DONE);
  assign o_diff    = r_diff;
  assign o_bout    = r_bout;
  assign o_neg     = r_neg;
  assign o_err     = r_err;

  assign w_capture = i_start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last    = (r_cnt == CW'(N_DIGITS - 1));

  // Operand registers are untouched until the first SUB cycle, so check them there.
  always_comb begin
    w_in_err = 1'b0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if ((r_a[i*DIGIT_W +: DIGIT_W] > BCD_MAX) || (r_b[i*DIGIT_W +: DIGIT_W] > BCD_MAX)) begin
        w_in_err = 1'b1;
      end
    end
  end

  // NEG pass reuses the digit unit as 0 - diff_i - brw2.
  assign w_x = (r_state == NEG) ? 4'd0 : r_a[DIGIT_W-1:0];
  assign w_y = (r_state == NEG) ? r_diff[DIGIT_W-1:0] : r_b[DIGIT_W-1:0];

  bcd_sub_digit u_digit (
    .i_x       (w_x),
    .i_y       (w_y),
    .i_brw_in  (r_brw),
    .o_d       (w_d),
    .o_brw_out (w_brw_out)
  );

  assign w_diff_shift = (r_diff >> DIGIT_W) | (W'(w_d) << (W - DIGIT_W));

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_capture) w_state_next = SUB;
      SUB: begin
        if ((r_cnt == '0) && w_in_err) w_state_next = DONE;
        else if (w_last)               w_state_next = (SIGNED_MAG && w_brw_out) ? NEG : DONE;
      end
      NEG:     if (w_last) w_state_next = DONE;
      DONE:    w_state_next = w_capture ? SUB : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_diff <= '0;
      r_cnt  <= '0;
      r_brw  <= 1'b0;
      r_bout <= 1'b0;
      r_neg  <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_capture) begin
      r_a    <= i_a;
      r_b    <= i_b;
      r_brw  <= i_bin;
      r_diff <= '0;
      r_cnt  <= '0;
      r_bout <= 1'b0;
      r_neg  <= 1'b0;
      r_err  <= 1'b0;
    end else if (r_state == SUB) begin
      if ((r_cnt == '0) && w_in_err) begin
        r_err <= 1'b1;
      end else begin
        r_a    <= r_a >> DIGIT_W;
        r_b    <= r_b >> DIGIT_W;
        r_diff <= w_diff_shift;
        r_brw  <= w_brw_out;
        if (w_last) begin
          r_cnt  <= '0;
          r_bout <= w_brw_out;
          if (SIGNED_MAG && w_brw_out) begin
            r_neg <= 1'b1;
            r_brw <= 1'b0;
          end
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end else if (r_state == NEG) begin
      r_diff <= w_diff_shift;
      r_brw  <= w_brw_out;
      r_cnt  <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Bench for bcd_serial_subtractor: both SIGNED_MAG variants side by side, scoreboard queues.
module tb_bcd_serial_subtractor;

  typedef struct {
    string       tag;
    logic [15:0] diff;
    logic        bout;
    logic        neg;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start, bin;
  logic [15:0] a, b;
  logic        busy0, done0, bout0, neg0, err0;
  logic        busy1, done1, bout1, neg1, err1;
  logic [15:0] diff0, diff1;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  bcd_serial_subtractor #(.N_DIGITS(4), .SIGNED_MAG(1'b0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_a(a), .i_b(b), .i_bin(bin),
    .o_busy(busy0), .o_done(done0), .o_diff(diff0), .o_bout(bout0), .o_neg(neg0), .o_err(err0)
  );

  bcd_serial_subtractor #(.N_DIGITS(4), .SIGNED_MAG(1'b1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_a(a), .i_b(b), .i_bin(bin),
    .o_busy(busy1), .o_done(done1), .o_diff(diff1), .o_bout(bout1), .o_neg(neg1), .o_err(err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int which, input string tag, input logic [15:0] d, input logic bo,
                      input logic ng, input logic er, input int lat);
    exp_t e;
    e.tag = tag; e.diff = d; e.bout = bo; e.neg = ng; e.err = er; e.lat = lat;
    if (which == 0) q0.push_back(e);
    else            q1.push_back(e);
  endtask

  function automatic int dec(input logic [15:0] v);
    int r = 0;
    for (int k = 3; k >= 0; k--) r = r * 10 + int'(v[k*4 +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    for (int k = 0; k < 4; k++) begin
      r[k*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Integer reference: signed decimal difference, then ten's complement or magnitude.
  task automatic push_model(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                            input logic ibin);
    int r;
    r = dec(ia) - dec(ib) - int'(ibin);
    if (r < 0) begin
      push(0, tag, to_bcd(r + 10000), 1'b1, 1'b0, 1'b0, 4);
      push(1, tag, to_bcd(-r), 1'b1, 1'b1, 1'b0, 8);
    end else begin
      push(0, tag, to_bcd(r), 1'b0, 1'b0, 1'b0, 4);
      push(1, tag, to_bcd(r), 1'b0, 1'b0, 1'b0, 4);
    end
  endtask

  task automatic launch(input logic [15:0] ia, input logic [15:0] ib, input logic ibin,
                        input bit hold);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    chk("capture clears err0", {31'd0, err0}, 32'd0);
    chk("capture clears diff0", {16'd0, diff0}, 32'd0);
    chk("capture clears neg1", {31'd0, neg1}, 32'd0);
  endtask

  task automatic check_done(input int which, input int k);
    exp_t e;
    if (which == 0) begin
      if (q0.size() == 0) begin
        chk("unexpected done0", 32'd1, 32'd0);
        return;
      end
      e = q0.pop_front();
      chk({e.tag, " diff0"}, {16'd0, diff0}, {16'd0, e.diff});
      chk({e.tag, " bout0"}, {31'd0, bout0}, {31'd0, e.bout});
      chk({e.tag, " neg0"}, {31'd0, neg0}, {31'd0, e.neg});
      chk({e.tag, " err0"}, {31'd0, err0}, {31'd0, e.err});
      chk({e.tag, " busy0"}, {31'd0, busy0}, 32'd0);
    end else begin
      if (q1.size() == 0) begin
        chk("unexpected done1", 32'd1, 32'd0);
        return;
      end
      e = q1.pop_front();
      chk({e.tag, " diff1"}, {16'd0, diff1}, {16'd0, e.diff});
      chk({e.tag, " bout1"}, {31'd0, bout1}, {31'd0, e.bout});
      chk({e.tag, " neg1"}, {31'd0, neg1}, {31'd0, e.neg});
      chk({e.tag, " err1"}, {31'd0, err1}, {31'd0, e.err});
      chk({e.tag, " busy1"}, {31'd0, busy1}, 32'd0);
    end
    chk({e.tag, which == 0 ? " latency0" : " latency1"}, k, e.lat);
  endtask

  // Waits (bounded) for both DUTs to pulse done; optionally drops a held start
  // on the first done, or pulses a stray start at cycle pulse_at.
  task automatic monitor(input bit hold, input int pulse_at);
    int k    = 0;
    bit got0 = 0;
    bit got1 = 0;
    while (!(got0 && got1) && k < 20) begin
      @(posedge clk);
      #1;
      k++;
      if (done0) begin check_done(0, k); got0 = 1; end
      else if (!got0) chk("busy0 during op", {31'd0, busy0}, 32'd1);
      if (done1) begin check_done(1, k); got1 = 1; end
      else if (!got1) chk("busy1 during op", {31'd0, busy1}, 32'd1);
      if (hold && (got0 || got1)) start = 1'b0;
      if (k == pulse_at) begin
        start = 1'b1; a = 16'h9999; b = 16'h0000; bin = 1'b1;
      end else if (k == pulse_at + 1) begin
        start = 1'b0;
      end
    end
    if (!got0) chk("timeout waiting done0", 32'd0, 32'd1);
    if (!got1) chk("timeout waiting done1", 32'd0, 32'd1);
  endtask

  task automatic check_idle(input string tag);
    @(posedge clk);
    #1;
    chk({tag, " busy0"}, {31'd0, busy0}, 32'd0);
    chk({tag, " done0"}, {31'd0, done0}, 32'd0);
    chk({tag, " busy1"}, {31'd0, busy1}, 32'd0);
    chk({tag, " done1"}, {31'd0, done1}, 32'd0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rbin;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset busy0", {31'd0, busy0}, 32'd0);
    chk("reset done0", {31'd0, done0}, 32'd0);
    chk("reset diff0", {16'd0, diff0}, 32'd0);
    chk("reset bout0", {31'd0, bout0}, 32'd0);
    chk("reset err0", {31'd0, err0}, 32'd0);
    chk("reset neg1", {31'd0, neg1}, 32'd0);

    // Start held high through the whole op: exactly one capture.
    push(0, "0042-0017", 16'h0025, 1'b0, 1'b0, 1'b0, 4);
    push(1, "0042-0017", 16'h0025, 1'b0, 1'b0, 1'b0, 4);
    @(negedge clk);
    launch(16'h0042, 16'h0017, 1'b0, 1'b1);
    monitor(1'b1, -1);
    check_idle("held start single capture");

    push(0, "0017-0042", 16'h9975, 1'b1, 1'b0, 1'b0, 4);
    push(1, "0017-0042", 16'h0025, 1'b1, 1'b1, 1'b0, 8);
    @(negedge clk);
    launch(16'h0017, 16'h0042, 1'b0, 1'b0);
    monitor(1'b0, -1);

    push(0, "0000-0000-1", 16'h9999, 1'b1, 1'b0, 1'b0, 4);
    push(1, "0000-0000-1", 16'h0001, 1'b1, 1'b1, 1'b0, 8);
    @(negedge clk);
    launch(16'h0000, 16'h0000, 1'b1, 1'b0);
    monitor(1'b0, -1);

    push(0, "9999-0000", 16'h9999, 1'b0, 1'b0, 1'b0, 4);
    push(1, "9999-0000", 16'h9999, 1'b0, 1'b0, 1'b0, 4);
    @(negedge clk);
    launch(16'h9999, 16'h0000, 1'b0, 1'b0);
    monitor(1'b0, -1);

    push(0, "bad digit", 16'h0000, 1'b0, 1'b0, 1'b1, 1);
    push(1, "bad digit", 16'h0000, 1'b0, 1'b0, 1'b1, 1);
    @(negedge clk);
    launch(16'h00A0, 16'h0001, 1'b0, 1'b0);
    monitor(1'b0, -1);

    // Valid op after an error, then two back-to-back starts in the done cycle.
    push(0, "0005-0003", 16'h0002, 1'b0, 1'b0, 1'b0, 4);
    push(1, "0005-0003", 16'h0002, 1'b0, 1'b0, 1'b0, 4);
    @(negedge clk);
    launch(16'h0005, 16'h0003, 1'b0, 1'b0);
    monitor(1'b0, -1);
    push(0, "b2b 0100-0001", 16'h0099, 1'b0, 1'b0, 1'b0, 4);
    push(1, "b2b 0100-0001", 16'h0099, 1'b0, 1'b0, 1'b0, 4);
    launch(16'h0100, 16'h0001, 1'b0, 1'b0);
    monitor(1'b0, -1);
    push(0, "b2b zero", 16'h0000, 1'b0, 1'b0, 1'b0, 4);
    push(1, "b2b zero", 16'h0000, 1'b0, 1'b0, 1'b0, 4);
    launch(16'h0050, 16'h0050, 1'b0, 1'b0);
    monitor(1'b0, -1);

    // Stray start while busy must be dropped, not queued.
    push(0, "busy pulse", 16'h0025, 1'b0, 1'b0, 1'b0, 4);
    push(1, "busy pulse", 16'h0025, 1'b0, 1'b0, 1'b0, 4);
    @(negedge clk);
    launch(16'h0042, 16'h0017, 1'b0, 1'b0);
    monitor(1'b0, 2);
    repeat (3) check_idle("no queued start");

    // Reset in the middle of an op.
    @(negedge clk);
    launch(16'h0042, 16'h0017, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid-op reset busy0", {31'd0, busy0}, 32'd0);
    chk("mid-op reset done0", {31'd0, done0}, 32'd0);
    chk("mid-op reset diff0", {16'd0, diff0}, 32'd0);
    chk("mid-op reset busy1", {31'd0, busy1}, 32'd0);
    chk("mid-op reset diff1", {16'd0, diff1}, 32'd0);

    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < 4; k++) begin
        ra[k*4 +: 4] = 4'($urandom_range(0, 9));
        rb[k*4 +: 4] = 4'($urandom_range(0, 9));
      end
      rbin = 1'($urandom_range(0, 1));
      push_model($sformatf("rand %04h-%04h-%0d", ra, rb, rbin), ra, rb, rbin);
      @(negedge clk);
      launch(ra, rb, rbin, 1'b0);
      monitor(1'b0, -1);
    end

    chk("scoreboard0 drained", q0.size(), 32'd0);
    chk("scoreboard1 drained", q1.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
